// File: rtl/step_pkg.sv
// Shared types and default parameters for the step_gen per-axis step pulse generator.
package step_pkg;

    localparam int STEP_CNT_WIDTH     = 32;
    localparam int STEP_PER_WIDTH     = 32;
    localparam int MIN_PERIOD_DEFAULT = 400;
    localparam int DIR_SETUP_DEFAULT  = 4;

    typedef struct packed {
        logic signed [STEP_CNT_WIDTH-1:0] steps;
        logic        [STEP_PER_WIDTH-1:0] period;
    } step_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN
    } step_state_t;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter that stops at zero; tc is high in the cycle its count reads 1.
// A load of N therefore places the next tc-driven event N clocks after the loading edge.
module step_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
        if (sclr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == WIDTH'(1));

endmodule

// File: rtl/step_gen.sv
// Per-axis step/dir pulse generator with a one-deep segment holding register.
// Define STEP_GEN_POS_EN to add a signed position counter (pos_clr in, pos out).
module step_gen
    import step_pkg::*;
#(
    parameter int CNT_WIDTH  = STEP_CNT_WIDTH,
    parameter int PER_WIDTH  = STEP_PER_WIDTH,
    parameter int MIN_PERIOD = MIN_PERIOD_DEFAULT,
    parameter int DIR_SETUP  = DIR_SETUP_DEFAULT
) (
    input  logic                        clk,
    input  logic                        aclr_n,
    input  logic                        sclr,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic signed [CNT_WIDTH-1:0] cmd_steps,
    input  logic        [PER_WIDTH-1:0] cmd_period,
    output logic                        step,
    output logic                        dir,
    output logic                        busy,
    output logic                        done,
`ifdef STEP_GEN_POS_EN
    input  logic                        pos_clr,
    output logic signed [CNT_WIDTH-1:0] pos,
`endif
    output logic        [CNT_WIDTH-1:0] remaining
);

    localparam logic [PER_WIDTH-1:0] MIN_P    = PER_WIDTH'(MIN_PERIOD);
    localparam logic [PER_WIDTH-1:0] SETUP_P  = PER_WIDTH'(DIR_SETUP);
    localparam logic [PER_WIDTH-1:0] CHANGE_P = PER_WIDTH'(DIR_SETUP + 1);

    step_state_t          state_q, state_d;
    logic                 pend_full_q, pend_full_d;
    logic [CNT_WIDTH-1:0] pend_steps_q, pend_steps_d;
    logic [PER_WIDTH-1:0] pend_per_q, pend_per_d;
    logic [PER_WIDTH-1:0] per_q, per_d;
    logic                 seg_dir_q, seg_dir_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                 step_q, step_d, dir_q, dir_d;
    logic                 done_q, done_d, busy_q, busy_d;

    logic                 accept, take, nxt_valid, nxt_dir;
    logic [CNT_WIDTH-1:0] nxt_steps, nxt_mag;
    logic [PER_WIDTH-1:0] nxt_per, nxt_p, timer_val;
    logic                 timer_load, timer_tc;

    // The next segment comes from the holding register, or straight from the
    // command port when it lands on the same edge as the last step.
    always_comb begin
        accept    = cmd_valid && !pend_full_q;
        nxt_valid = pend_full_q || cmd_valid;
        nxt_steps = pend_full_q ? pend_steps_q : cmd_steps;
        nxt_per   = pend_full_q ? pend_per_q : cmd_period;
        nxt_dir   = nxt_steps[CNT_WIDTH-1];
        nxt_mag   = nxt_dir ? -nxt_steps : nxt_steps;
        nxt_p     = (nxt_per < MIN_P) ? MIN_P : nxt_per;
    end

    always_comb begin
        state_d      = state_q;
        pend_full_d  = pend_full_q;
        pend_steps_d = pend_steps_q;
        pend_per_d   = pend_per_q;
        per_d        = per_q;
        seg_dir_d    = seg_dir_q;
        remaining_d  = remaining_q;
        step_d       = 1'b0;
        dir_d        = dir_q;
        done_d       = 1'b0;
        take         = 1'b0;
        timer_load   = 1'b0;
        timer_val    = per_q;

        if (state_q == SETUP) begin
            dir_d = seg_dir_q;
        end

        if (state_q == IDLE) begin
            if (pend_full_q) begin
                take = 1'b1;
                if (nxt_mag == '0) begin
                    done_d = 1'b1;
                end else begin
                    dir_d       = nxt_dir;
                    seg_dir_d   = nxt_dir;
                    remaining_d = nxt_mag;
                    per_d       = nxt_p;
                    timer_load  = 1'b1;
                    timer_val   = SETUP_P;
                    state_d     = SETUP;
                end
            end
        end else if (timer_tc) begin
            step_d      = 1'b1;
            remaining_d = remaining_q - CNT_WIDTH'(1);
            timer_load  = 1'b1;
            state_d     = RUN;
            if (remaining_q == CNT_WIDTH'(1)) begin
                done_d = 1'b1;
                // A zero-length segment is left for IDLE so its done pulse stays separate.
                if (nxt_valid && nxt_mag != '0) begin
                    take        = 1'b1;
                    remaining_d = nxt_mag;
                    per_d       = nxt_p;
                    seg_dir_d   = nxt_dir;
                    if (nxt_dir == seg_dir_q) begin
                        timer_val = nxt_p;
                    end else begin
                        timer_val = (nxt_p > CHANGE_P) ? nxt_p : CHANGE_P;
                        state_d   = SETUP;
                    end
                end else begin
                    timer_load = 1'b0;
                    state_d    = IDLE;
                end
            end
        end

        if (take && pend_full_q) begin
            pend_full_d = 1'b0;
        end else if (accept && !take) begin
            pend_full_d  = 1'b1;
            pend_steps_d = cmd_steps;
            pend_per_d   = cmd_period;
        end

        if (sclr) begin
            state_d     = IDLE;
            pend_full_d = 1'b0;
            seg_dir_d   = 1'b0;
            remaining_d = '0;
            step_d      = 1'b0;
            dir_d       = 1'b0;
            done_d      = 1'b0;
            timer_load  = 1'b0;
        end

        busy_d = (state_d != IDLE) || pend_full_d || done_d;
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q      <= IDLE;
            pend_full_q  <= 1'b0;
            pend_steps_q <= '0;
            pend_per_q   <= '0;
            per_q        <= '0;
            seg_dir_q    <= 1'b0;
            remaining_q  <= '0;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_full_q  <= pend_full_d;
            pend_steps_q <= pend_steps_d;
            pend_per_q   <= pend_per_d;
            per_q        <= per_d;
            seg_dir_q    <= seg_dir_d;
            remaining_q  <= remaining_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    step_timer #(
        .WIDTH (PER_WIDTH)
    ) u_timer (
        .clk      (clk),
        .aclr_n   (aclr_n),
        .sclr     (sclr),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (timer_tc)
    );

`ifdef STEP_GEN_POS_EN
    logic signed [CNT_WIDTH-1:0] pos_q, pos_d;

    // Counts the strobe one clock late so a pos_clr seen during the strobe cycle wins.
    always_comb begin
        pos_d = pos_q;
        if (step_q) begin
            pos_d = dir_q ? pos_q - CNT_WIDTH'(1) : pos_q + CNT_WIDTH'(1);
        end
        if (pos_clr || sclr) begin
            pos_d = '0;
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;
`endif

    assign cmd_ready = !pend_full_q;
    assign step      = step_q;
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = remaining_q;

endmodule
